// File: rtl/game_pkg.sv
// Shared game constants: position field layout, screen and sprite sizes, scanner FSM states.
package game_pkg;

    localparam int unsigned POS_W     = 19;
    localparam int unsigned X_MSB     = 18;
    localparam int unsigned X_LSB     = 9;
    localparam int unsigned Y_MSB     = 8;
    localparam int unsigned Y_LSB     = 0;
    localparam int unsigned X_W       = X_MSB - X_LSB + 1;
    localparam int unsigned Y_W       = Y_MSB - Y_LSB + 1;

    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;

    localparam int unsigned ENEMY_W   = 32;
    localparam int unsigned ENEMY_H   = 24;
    localparam int unsigned PLAYER_W  = 20;
    localparam int unsigned PLAYER_H  = 16;
    localparam int unsigned BOX_DIM_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        SCAN_PB,
        SCAN_EB,
        DONE
    } scanState_t;

endpackage

// File: rtl/point_in_box.sv
// Combinational point-in-rectangle test: origin inclusive, origin+size exclusive, no wrap-around.
module point_in_box
    import game_pkg::*;
(
    input  logic [POS_W-1:0]     point,
    input  logic [POS_W-1:0]     origin,
    input  logic [BOX_DIM_W-1:0] boxW,
    input  logic [BOX_DIM_W-1:0] boxH,
    output logic                 hit
);

    logic [X_W:0] px, ox, xEnd;
    logic [Y_W:0] py, oy, yEnd;

    // One extra bit on every coordinate so origin+size cannot overflow.
    always_comb begin
        px   = {1'b0, point[X_MSB:X_LSB]};
        ox   = {1'b0, origin[X_MSB:X_LSB]};
        py   = {1'b0, point[Y_MSB:Y_LSB]};
        oy   = {1'b0, origin[Y_MSB:Y_LSB]};
        xEnd = ox + (X_W + 1)'(boxW);
        yEnd = oy + (Y_W + 1)'(boxH);
        hit  = (px >= ox) && (px < xEnd) && (py >= oy) && (py < yEnd);
    end

endmodule

// File: rtl/bullet_collision_scanner.sv
// Per-frame collision scan: one bullet/target pair per clock through a single shared box comparator.
module bullet_collision_scanner
    import game_pkg::*;
#(
    parameter int unsigned N_ENEMY         = 15,
    parameter int unsigned N_ENEMY_BULLET  = 31,
    parameter int unsigned N_PLAYER_BULLET = 15
) (
    input  logic                               i_Clk,
    input  logic                               i_Rst,
    input  logic                               i_Start,
    input  logic [N_ENEMY-1:0]                 i_EnemyAlive,
    input  logic [N_ENEMY_BULLET-1:0]          i_EnemyBulletState,
    input  logic                               i_PlayerState,
    input  logic [N_PLAYER_BULLET-1:0]         i_PlayerBulletState,
    input  logic [POS_W*N_ENEMY-1:0]           i_EnemyPosition,
    input  logic [POS_W*N_ENEMY_BULLET-1:0]    i_EnemyBulletPosition,
    input  logic [POS_W-1:0]                   i_PlayerPosition,
    input  logic [POS_W*N_PLAYER_BULLET-1:0]   i_PlayerBulletPosition,
    output logic [N_ENEMY-1:0]                 o_EnemyHit,
    output logic [N_PLAYER_BULLET-1:0]         o_PlayerBulletKill,
    output logic [N_ENEMY_BULLET-1:0]          o_EnemyBulletKill,
    output logic                               o_PlayerHit,
    output logic                               o_Busy,
    output logic                               o_Done
);

    localparam int unsigned P_W = $clog2(N_PLAYER_BULLET);
    localparam int unsigned E_W = $clog2(N_ENEMY);
    localparam int unsigned Q_W = $clog2(N_ENEMY_BULLET);

    scanState_t state;
    logic [P_W-1:0] p;
    logic [E_W-1:0] e;
    logic [Q_W-1:0] q;

    logic [N_ENEMY-1:0]         enemyAliveSnap;
    logic [N_ENEMY_BULLET-1:0]  ebStateSnap;
    logic [N_PLAYER_BULLET-1:0] pbStateSnap;
    logic                       playerStateSnap;
    logic [POS_W-1:0]           enemyPosSnap [N_ENEMY];
    logic [POS_W-1:0]           ebPosSnap    [N_ENEMY_BULLET];
    logic [POS_W-1:0]           pbPosSnap    [N_PLAYER_BULLET];
    logic [POS_W-1:0]           playerPosSnap;

    logic [N_ENEMY-1:0]         hitE;
    logic [N_PLAYER_BULLET-1:0] pbKill;
    logic [N_ENEMY_BULLET-1:0]  ebKill;
    logic                       plHit;

    logic                 inEb;
    logic [POS_W-1:0]     boxPoint;
    logic [POS_W-1:0]     boxOrigin;
    logic [BOX_DIM_W-1:0] boxW;
    logic [BOX_DIM_W-1:0] boxH;
    logic                 boxHit;
    logic                 pointOffscreen;

    // Operand mux: player-bullet vs enemy in SCAN_PB, enemy-bullet vs player in SCAN_EB.
    always_comb begin
        inEb           = (state == SCAN_EB);
        boxPoint       = inEb ? ebPosSnap[q] : pbPosSnap[p];
        boxOrigin      = inEb ? playerPosSnap : enemyPosSnap[e];
        boxW           = inEb ? BOX_DIM_W'(PLAYER_W) : BOX_DIM_W'(ENEMY_W);
        boxH           = inEb ? BOX_DIM_W'(PLAYER_H) : BOX_DIM_W'(ENEMY_H);
        pointOffscreen = ({1'b0, boxPoint[Y_MSB:Y_LSB]} >= (Y_W + 1)'(SCREEN_H));
    end

    point_in_box boxCmp (
        .point  (boxPoint),
        .origin (boxOrigin),
        .boxW   (boxW),
        .boxH   (boxH),
        .hit    (boxHit)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state              <= IDLE;
            p                  <= '0;
            e                  <= '0;
            q                  <= '0;
            enemyAliveSnap     <= '0;
            ebStateSnap        <= '0;
            pbStateSnap        <= '0;
            playerStateSnap    <= 1'b0;
            playerPosSnap      <= '0;
            for (int unsigned k = 0; k < N_ENEMY; k++)         enemyPosSnap[k] <= '0;
            for (int unsigned k = 0; k < N_ENEMY_BULLET; k++)  ebPosSnap[k]    <= '0;
            for (int unsigned k = 0; k < N_PLAYER_BULLET; k++) pbPosSnap[k]    <= '0;
            hitE               <= '0;
            pbKill             <= '0;
            ebKill             <= '0;
            plHit              <= 1'b0;
            o_EnemyHit         <= '0;
            o_PlayerBulletKill <= '0;
            o_EnemyBulletKill  <= '0;
            o_PlayerHit        <= 1'b0;
            o_Busy             <= 1'b0;
            o_Done             <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Start) begin
                        enemyAliveSnap  <= i_EnemyAlive;
                        ebStateSnap     <= i_EnemyBulletState;
                        pbStateSnap     <= i_PlayerBulletState;
                        playerStateSnap <= i_PlayerState;
                        playerPosSnap   <= i_PlayerPosition;
                        for (int unsigned k = 0; k < N_ENEMY; k++)
                            enemyPosSnap[k] <= i_EnemyPosition[k*POS_W +: POS_W];
                        for (int unsigned k = 0; k < N_ENEMY_BULLET; k++)
                            ebPosSnap[k] <= i_EnemyBulletPosition[k*POS_W +: POS_W];
                        for (int unsigned k = 0; k < N_PLAYER_BULLET; k++)
                            pbPosSnap[k] <= i_PlayerBulletPosition[k*POS_W +: POS_W];
                        hitE   <= '0;
                        pbKill <= '0;
                        ebKill <= '0;
                        plHit  <= 1'b0;
                        p      <= '0;
                        e      <= '0;
                        q      <= '0;
                        o_Busy <= 1'b1;
                        state  <= SCAN_PB;
                    end
                end

                SCAN_PB: begin
                    // Marked bullets are skipped, so each bullet lands on the lowest-index enemy only.
                    if (pbStateSnap[p] && enemyAliveSnap[e] && !pbKill[p] && boxHit) begin
                        hitE[e]   <= 1'b1;
                        pbKill[p] <= 1'b1;
                    end
                    if ((e == '0) && pbStateSnap[p] && pointOffscreen)
                        pbKill[p] <= 1'b1;

                    if (e == E_W'(N_ENEMY - 1)) begin
                        e <= '0;
                        if (p == P_W'(N_PLAYER_BULLET - 1)) begin
                            p     <= '0;
                            state <= SCAN_EB;
                        end else begin
                            p <= p + 1'b1;
                        end
                    end else begin
                        e <= e + 1'b1;
                    end
                end

                SCAN_EB: begin
                    if (ebStateSnap[q] && (pointOffscreen || (playerStateSnap && boxHit)))
                        ebKill[q] <= 1'b1;
                    if (ebStateSnap[q] && playerStateSnap && boxHit)
                        plHit <= 1'b1;

                    if (q == Q_W'(N_ENEMY_BULLET - 1)) begin
                        q     <= '0;
                        state <= DONE;
                    end else begin
                        q <= q + 1'b1;
                    end
                end

                DONE: begin
                    o_EnemyHit         <= hitE;
                    o_PlayerBulletKill <= pbKill;
                    o_EnemyBulletKill  <= ebKill;
                    o_PlayerHit        <= plHit;
                    o_Done             <= 1'b1;
                    o_Busy             <= 1'b0;
                    state              <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
